serial_bus_master_p: RTL and testbench

//  Parametrised serial bus master, successor to the fixed 14/8-bit master.
//  - Accepts one read or write request per valid/ready handshake.
//  - Arbitrates for the shared serial bus and shifts the address (and write

---
 rtl/serial_bus_master_p.sv | 194 +++++++++++++++++++
 tb/tb_serial_bus_master_p.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master_p.sv
// Parametrised serial bus master: accepts one request per handshake, arbitrates
// for the bus, shifts address/write data out MSB first and optionally reads data back.
module serial_bus_master_p #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              bus_req,
    input  logic              bus_ready,
    output logic              addr_tx,
    output logic              data_tx,
    output logic              valid_s,
    output logic              write_en_slave,
    input  logic              data_rx,
    input  logic              slave_valid,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              master_busy
);

    localparam int M1 = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MX = (M1 > TIMEOUT) ? M1 : TIMEOUT;
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_WAIT, S_RX, S_DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              read_q, read_n;
    logic [ADDR_W-1:0] addr_sr, addr_sr_n;
    logic [ADDR_W-1:0] data_sr, data_sr_n;
    logic [DATA_W-1:0] rx_sr, rx_sr_n;
    logic [DATA_W-1:0] rdata_n;
    logic              err_n;
    logic              req_ready_n, bus_req_n, addr_tx_n, data_tx_n, valid_s_n;
    logic              we_n, rsp_valid_n, busy_n;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        read_n      = read_q;
        addr_sr_n   = addr_sr;
        data_sr_n   = data_sr;
        rx_sr_n     = rx_sr;
        rdata_n     = rsp_rdata;
        err_n       = rsp_err;
        req_ready_n = 1'b0;
        bus_req_n   = 1'b0;
        addr_tx_n   = 1'b0;
        data_tx_n   = 1'b0;
        valid_s_n   = 1'b0;
        we_n        = 1'b0;
        rsp_valid_n = 1'b0;
        busy_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_n   = S_REQ;
                    read_n    = req_read;
                    addr_sr_n = req_addr;
                    // write data zero-extended so its LSB lines up with the address LSB
                    data_sr_n = req_read ? '0 : ADDR_W'(req_wdata);
                    rx_sr_n   = '0;
                    cnt_n     = '0;
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    state_n = S_ADDR;
                    cnt_n   = '0;
                end
            end
            S_ADDR: begin
                if (cnt == ADDR_LAST) begin
                    cnt_n = '0;
                    if (read_q) begin
                        state_n = S_WAIT;
                    end else begin
                        state_n = S_DONE;
                        rdata_n = '0;
                        err_n   = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (slave_valid) begin
                    state_n = S_RX;
                    cnt_n   = '0;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                    rdata_n = '0;
                    err_n   = 1'b1;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RX: begin
                rx_sr_n = (rx_sr << 1) | DATA_W'(data_rx);
                if (cnt == DATA_LAST) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                    rdata_n = rx_sr_n;
                    err_n   = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        case (state_n)
            S_IDLE: req_ready_n = 1'b1;
            S_REQ: begin
                bus_req_n = 1'b1;
                busy_n    = 1'b1;
            end
            S_ADDR: begin
                bus_req_n = 1'b1;
                busy_n    = 1'b1;
                valid_s_n = 1'b1;
                we_n      = ~read_q;
                addr_tx_n = addr_sr[ADDR_W-1];
                data_tx_n = data_sr[ADDR_W-1];
                addr_sr_n = addr_sr << 1;
                data_sr_n = data_sr << 1;
            end
            S_WAIT, S_RX: begin
                bus_req_n = 1'b1;
                busy_n    = 1'b1;
            end
            S_DONE: begin
                busy_n      = 1'b1;
                rsp_valid_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            read_q         <= 1'b0;
            addr_sr        <= '0;
            data_sr        <= '0;
            rx_sr          <= '0;
            req_ready      <= 1'b0;
            bus_req        <= 1'b0;
            addr_tx        <= 1'b0;
            data_tx        <= 1'b0;
            valid_s        <= 1'b0;
            write_en_slave <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            master_busy    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            read_q         <= read_n;
            addr_sr        <= addr_sr_n;
            data_sr        <= data_sr_n;
            rx_sr          <= rx_sr_n;
            req_ready      <= req_ready_n;
            bus_req        <= bus_req_n;
            addr_tx        <= addr_tx_n;
            data_tx        <= data_tx_n;
            valid_s        <= valid_s_n;
            write_en_slave <= we_n;
            rsp_valid      <= rsp_valid_n;
            rsp_rdata      <= rdata_n;
            rsp_err        <= err_n;
            master_busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_serial_bus_master_p.sv
// Bench for serial_bus_master_p: a 14/8/64 and a 16/16/0 instance, checked
// cycle by cycle against a timeline computed from the transaction parameters.
module tb_serial_bus_master_p;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sel;
    logic        req_valid, req_read;
    logic [15:0] req_addr, req_wdata;
    logic        bus_ready, data_rx, slave_valid;

    logic        a_req_ready, a_bus_req, a_addr_tx, a_data_tx, a_valid_s, a_we;
    logic        a_rsp_valid, a_rsp_err, a_busy;
    logic [7:0]  a_rdata;
    logic        b_req_ready, b_bus_req, b_addr_tx, b_data_tx, b_valid_s, b_we;
    logic        b_rsp_valid, b_rsp_err, b_busy;
    logic [15:0] b_rdata;

    logic        o_req_ready, o_bus_req, o_addr_tx, o_data_tx, o_valid_s, o_we;
    logic        o_rsp_valid, o_rsp_err, o_busy;
    logic [15:0] o_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    serial_bus_master_p #(.ADDR_W(14), .DATA_W(8), .TIMEOUT(64)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_read(req_read),
        .req_addr(req_addr[13:0]), .req_wdata(req_wdata[7:0]),
        .bus_req(a_bus_req), .bus_ready(bus_ready),
        .addr_tx(a_addr_tx), .data_tx(a_data_tx), .valid_s(a_valid_s),
        .write_en_slave(a_we), .data_rx(data_rx), .slave_valid(slave_valid),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err),
        .master_busy(a_busy)
    );

    serial_bus_master_p #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .bus_req(b_bus_req), .bus_ready(bus_ready),
        .addr_tx(b_addr_tx), .data_tx(b_data_tx), .valid_s(b_valid_s),
        .write_en_slave(b_we), .data_rx(data_rx), .slave_valid(slave_valid),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err),
        .master_busy(b_busy)
    );

    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_bus_req   = sel ? b_bus_req   : a_bus_req;
    assign o_addr_tx   = sel ? b_addr_tx   : a_addr_tx;
    assign o_data_tx   = sel ? b_data_tx   : a_data_tx;
    assign o_valid_s   = sel ? b_valid_s   : a_valid_s;
    assign o_we        = sel ? b_we        : a_we;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_rdata     = sel ? b_rdata     : {8'h00, a_rdata};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_a"}, {15'h0, a_req_ready, a_bus_req, a_addr_tx, a_data_tx, a_valid_s,
                             a_we, a_rsp_valid, a_rsp_err, a_busy, a_rdata}, 32'h0);
        check({name, "_b"}, {7'h0, b_req_ready, b_bus_req, b_addr_tx, b_data_tx, b_valid_s,
                             b_we, b_rsp_valid, b_rsp_err, b_busy, b_rdata}, 32'h0);
    endtask

    // gnt: cycles bus_ready stays low in REQ; sv: WAIT cycle index at which
    // slave_valid is driven (-1 = never); accept cycle is c = 0.
    task automatic run_txn(input logic rd, input logic [15:0] addr, input logic [15:0] wdata,
                           input int gnt, input int sv, input logic [15:0] rx, input logic rnd,
                           output int lat, output logic [15:0] rdata_exp, output logic err_exp);
        int aw, dw, tmo, a0, w0, rx0, done, wt, k;
        logic to_hit;
        logic [6:0] exp_v, msk, act_v;
        logic [15:0] wd, held;
        aw  = sel ? 16 : 14;
        dw  = sel ? 16 : 8;
        tmo = sel ? 0 : 64;
        wd  = (dw == 16) ? wdata : (wdata & 16'h00FF);
        a0  = gnt + 2;
        w0  = a0 + aw;
        rx0 = 0;
        to_hit = rd && (sv < 0 || (tmo != 0 && sv >= tmo));
        if (!rd)        done = w0;
        else if (to_hit) done = w0 + tmo;
        else begin
            rx0  = w0 + sv + 1;
            done = rx0 + dw;
        end
        rdata_exp = (rd && !to_hit) ? 16'(rx & ((32'h1 << dw) - 1)) : 16'h0;
        err_exp   = to_hit;
        lat  = -1;
        held = 16'h0;
        wt   = 0;
        while (!o_req_ready && wt < 8) begin
            @(posedge clock); #1;
            wt++;
        end
        check("req_ready_before_accept", {31'h0, o_req_ready}, 32'h1);
        if (!o_req_ready) return;
        req_valid   = 1'b1;
        req_read    = rd;
        req_addr    = addr;
        req_wdata   = wd;
        bus_ready   = 1'b0;
        slave_valid = 1'b0;
        data_rx     = 1'($urandom);
        for (int c = 1; c <= done + 1; c++) begin
            @(posedge clock); #1;
            // bits: bus_req valid_s rsp_valid we addr_tx data_tx req_ready
            if (c <= gnt + 1) begin
                msk = 7'b1110001; exp_v = 7'b1000000;
            end else if (c < w0) begin
                k     = c - a0;
                msk   = 7'b1111111;
                exp_v = {1'b1, 1'b1, 1'b0, ~rd, addr[aw-1-k],
                         (!rd && k >= aw - dw) ? wd[aw-1-k] : 1'b0, 1'b0};
            end else if (c < done) begin
                msk = 7'b0110001; exp_v = 7'b0000000;
                if (to_hit || c < rx0) msk[2] = 1'b1;
            end else if (c == done) begin
                msk = 7'b1110001; exp_v = 7'b0010000;
            end else begin
                msk = 7'b1110001; exp_v = 7'b0000001;
            end
            act_v = {o_bus_req, o_valid_s, o_rsp_valid, o_we, o_addr_tx, o_data_tx, o_req_ready};
            check($sformatf("cycle%0d_outputs", c), {25'h0, act_v & msk}, {25'h0, exp_v & msk});
            if (o_rsp_valid && lat < 0) lat = c;
            if (c == 1) check("busy_in_req", {31'h0, o_busy}, 32'h1);
            if (c == done) begin
                check("rsp_rdata", {16'h0, o_rdata}, {16'h0, rdata_exp});
                check("rsp_err", {31'h0, o_rsp_err}, {31'h0, err_exp});
                held = o_rdata;
            end
            if (c == done + 1) begin
                check("busy_after_done", {31'h0, o_busy}, 32'h0);
                check("rsp_rdata_hold", {16'h0, o_rdata}, {16'h0, held});
            end
            req_valid = (rnd && c <= done) ? 1'($urandom) : 1'b0;
            if (rnd) begin
                req_read  = 1'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end
            if (c <= gnt)                 bus_ready = 1'b0;
            else if (c == gnt + 1 || !rnd) bus_ready = 1'b1;
            else                          bus_ready = 1'($urandom);
            slave_valid = 1'b0;
            if (rd && !to_hit && c == w0 + sv)   slave_valid = 1'b1;
            else if (rnd && c >= a0 && c < w0)   slave_valid = 1'($urandom);
            data_rx = (rd && !to_hit && c >= rx0 && c < done) ? rx[dw-1-(c-rx0)] : 1'($urandom);
        end
    endtask

    typedef struct {
        logic        sel;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          gnt;
        int          sv;
        logic [15:0] rx;
        int          lat;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] re;
        logic        ee;

        tbl[0]  = '{1'b0, 1'b0, 16'h2A5C, 16'h00A7, 0,  -1, 16'h0000, 16,  16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 0,   2, 16'h005B, 27,  16'h005B, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h1234, 16'h0000, 0,  -1, 16'h00FF, 80,  16'h0000, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 16'h2A5C, 16'h00A7, 5,  -1, 16'h0000, 21,  16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h3FFF, 16'h0000, 0,   0, 16'h00FF, 25,  16'h00FF, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'h0001, 16'h0000, 0,  63, 16'h0081, 88,  16'h0081, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 16'h2000, 16'h0000, 0,  64, 16'h0055, 80,  16'h0000, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'hFFFF, 16'h8001, 0,  -1, 16'h0000, 18,  16'h0000, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'hA5C3, 16'h0000, 0,  99, 16'hC3A5, 134, 16'hC3A5, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0001, 16'hFFFE, 2,  -1, 16'h0000, 20,  16'h0000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 16'h8000, 16'h0000, 0,   0, 16'h0001, 35,  16'h0001, 1'b0};

        reset_n     = 1'b0;
        sel         = 1'b0;
        req_valid   = 1'b0;
        req_read    = 1'b0;
        req_addr    = 16'h0;
        req_wdata   = 16'h0;
        bus_ready   = 1'b0;
        slave_valid = 1'b0;
        data_rx     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset_state");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready_before_first_edge", {31'h0, a_req_ready}, 32'h0);
        @(posedge clock); #1;
        check("ready_after_first_edge_a", {31'h0, a_req_ready}, 32'h1);
        check("ready_after_first_edge_b", {31'h0, b_req_ready}, 32'h1);

        for (int i = 0; i < 11; i++) begin
            sel = tbl[i].sel;
            #1;
            run_txn(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].gnt, tbl[i].sv, tbl[i].rx,
                    1'b0, lat, re, ee);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_rdata", i), {16'h0, o_rdata}, {16'h0, tbl[i].rdata});
            check($sformatf("vec%0d_err", i), {31'h0, o_rsp_err}, {31'h0, tbl[i].err});
        end

        // Reset pulsed in the middle of the address phase (k = 7)
        sel = 1'b0;
        #1;
        req_valid = 1'b1;
        req_read  = 1'b0;
        req_addr  = 16'h2A5C;
        req_wdata = 16'h00A7;
        bus_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clock); #1;
            req_valid = 1'b0;
        end
        check("mid_frame_valid_s", {31'h0, a_valid_s}, 32'h1);
        check("mid_frame_addr_bit6", {31'h0, a_addr_tx}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clock); #1;
        check_all_zero("reset_held");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_reset_ready", {31'h0, a_req_ready}, 32'h1);
        check("post_reset_no_rsp", {31'h0, a_rsp_valid}, 32'h0);
        run_txn(1'b0, 16'h2A5C, 16'h00A7, 0, -1, 16'h0, 1'b0, lat, re, ee);
        check("post_reset_latency", lat, 16);

        for (int i = 0; i < 40; i++) begin
            logic        rd;
            logic [15:0] ad, wd, rx;
            int          gnt, sv;
            sel = (i % 4 == 3);
            #1;
            rd  = 1'($urandom);
            ad  = 16'($urandom);
            wd  = 16'($urandom);
            rx  = 16'($urandom);
            gnt = $urandom_range(0, 4);
            if (sel) sv = $urandom_range(0, 30);
            else     sv = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 70));
            run_txn(rd, ad, wd, gnt, sv, rx, 1'b1, lat, re, ee);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
